// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word size, reset PC
// default and the fetch FSM state encoding.
package inst_fetch_unit_pkg;

    localparam int                 WORD_W           = 16;
    localparam logic [WORD_W-1:0]  RESET_PC_DEFAULT = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Prefetch queue for the fetch unit: a small synchronous FIFO of
// {inst, pc} entries. The head entry drives the outputs directly.
// flush wins over push and pop on the same edge.
module inst_fetch_unit_fetch_queue #(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          wdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(QDEPTH):0]   count,
    output logic [WIDTH-1:0]          head
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;

    // Pointer and occupancy bookkeeping; depth is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents only matter while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(QDEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one read at a time on the
// shared memory bus, buffers returned words in a prefetch queue and hands
// them to decode. A redirect flushes the queue and restarts at redirect_pc.
// Optional build macro FETCH_STATS_EN adds fetch_count / drop_count.
//
// Handshake: an instruction transfers on a cycle where inst_valid and
// inst_ready are both high; while inst_valid is high and inst_ready low,
// inst and inst_pc hold their value. On the memory side readM stays high
// from request until the cycle mem_ready is seen.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int               WORD     = WORD_W,
    parameter int               QDEPTH   = 2,
    parameter logic [WORD-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               readM,
    output logic [WORD-1:0]    address,
    input  logic [WORD-1:0]    data,
    input  logic               mem_ready,
    input  logic               bus_busy,
    input  logic               redirect,
    input  logic [WORD-1:0]    redirect_pc,
    output logic [WORD-1:0]    inst,
    output logic [WORD-1:0]    inst_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output fetch_state_t       fsm_state
`ifdef FETCH_STATS_EN
    ,
    output logic [WORD-1:0]    fetch_count,
    output logic [WORD-1:0]    drop_count
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [WORD-1:0]    pc;
    logic               push;
    logic               pop;
    logic               q_full;
    logic               q_empty;
    logic [CW-1:0]      q_count;
    logic [2*WORD-1:0]  q_head;

    // Next-state logic. A new fetch only starts from IDLE, so at most one
    // read is outstanding; a redirect during a read waits it out in DROP.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && !bus_busy && !q_full) state_next = REQ;
            end
            REQ: begin
                if (mem_ready) begin
                    state_next = IDLE;
                    push       = ~redirect;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (mem_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // PC advances on each accepted word; redirect overrides. The bus
    // address is captured when a request is launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            address <= '0;
        end else begin
            if (redirect)  pc <= redirect_pc;
            else if (push) pc <= pc + WORD'(1);
            if (state == IDLE && state_next == REQ) address <= pc;
        end
    end

    assign pop = inst_valid & inst_ready;

    inst_fetch_unit_fetch_queue #(
        .QDEPTH (QDEPTH),
        .WIDTH  (2*WORD)
    ) fetch_queue (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({data, pc}),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count),
        .head  (q_head)
    );

    assign readM      = (state != IDLE);
    assign inst_valid = (q_count != '0);
    assign inst       = q_empty ? '0 : q_head[2*WORD-1:WORD];
    assign inst_pc    = q_empty ? '0 : q_head[WORD-1:0];
    assign fsm_state  = state;

    // A launch needs a free slot, so a push can never meet a full queue
    // without a simultaneous pop.
    assert property (@(posedge clk) disable iff (reset) !(push && q_full && !pop));

`ifdef FETCH_STATS_EN
    logic               discard;
    logic [WORD-1:0]    drop_inc;
    logic [WORD:0]      fetch_sum;
    logic [WORD:0]      drop_sum;

    assign discard   = mem_ready & ((state == DROP) | ((state == REQ) & redirect));
    assign drop_inc  = WORD'(discard) + (redirect ? WORD'(q_count) : '0);
    assign fetch_sum = {1'b0, fetch_count} + (WORD+1)'(push);
    assign drop_sum  = {1'b0, drop_count} + {1'b0, drop_inc};

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            drop_count  <= '0;
        end else begin
            fetch_count <= fetch_sum[WORD] ? '1 : fetch_sum[WORD-1:0];
            drop_count  <= drop_sum[WORD]  ? '1 : drop_sum[WORD-1:0];
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based behavioural model, per-cycle
// compare, directed scenarios with literal expectations, random phase.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    localparam int W  = 16;
    localparam int QD = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          readM, mem_ready, bus_busy, redirect, inst_valid, inst_ready;
    logic [W-1:0]  address, data, redirect_pc, inst, inst_pc;
    fetch_state_t  fsm_state;
`ifdef FETCH_STATS_EN
    logic [W-1:0]  fetch_count, drop_count;
`endif

    inst_fetch_unit #(.WORD(W), .QDEPTH(QD), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .readM       (readM),
        .address     (address),
        .data        (data),
        .mem_ready   (mem_ready),
        .bus_busy    (bus_busy),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .fsm_state   (fsm_state)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count),
        .drop_count  (drop_count)
`endif
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]    m_pc, m_addr;
    bit              m_busy, m_drop;
    logic [2*W-1:0]  exp_q[$];
    int              m_fetch, m_dropc;

    // stimulus knobs (-1 = random)
    int f_rdy = -1, f_busy = -1, f_lat = -1;
    int lat_lo = 0, lat_hi = 3, rdy_pct = 60, busy_pct = 15, redir_pm = 30, spur_pct = 5;
    bit f_redir = 0;
    logic [W-1:0] f_rpc = '0;
    int mem_wait = -1;
    bit prev_readM = 0;

    logic [W-1:0] addr_log[$], pc_log[$], inst_log[$];

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [W-1:0] at(input logic [W-1:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        m_pc = 16'h0000; m_addr = '0; m_busy = 0; m_drop = 0;
        exp_q.delete(); m_fetch = 0; m_dropc = 0; mem_wait = -1; prev_readM = 0;
    endtask

    task automatic clear_logs();
        addr_log.delete(); pc_log.delete(); inst_log.delete();
    endtask

    task automatic set_directed();
        f_rdy = 1; f_busy = 0; f_lat = 1; redir_pm = 0; spur_pct = 0;
    endtask

    // Reset with bus_busy held so the release edge does nothing.
    task automatic do_reset(input bit late);
        reset = 1'b1; redirect = 0; redirect_pc = '0; bus_busy = 1;
        inst_ready = 0; mem_ready = late; data = 16'hDEAD;
        repeat (2) @(negedge clk);
        chk("rst_readM", readM, 0);
        chk("rst_address", address, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_state", fsm_state, IDLE);
        model_init();
        reset = 1'b0;
    endtask

    // One clock: compare DUT to model, drive inputs, advance model.
    task automatic cycle();
        bit pop, push, start, discard, exp_v;
        @(negedge clk);
        exp_v = exp_q.size() > 0;
        chk("readM", readM, m_busy);
        if (m_busy) chk("address", address, m_addr);
        chk("inst_valid", inst_valid, exp_v);
        chk("inst", inst, exp_v ? exp_q[0][2*W-1:W] : '0);
        chk("inst_pc", inst_pc, exp_v ? exp_q[0][W-1:0] : '0);
        if (readM && !prev_readM) addr_log.push_back(address);
        prev_readM = readM;

        inst_ready  = (f_rdy >= 0) ? f_rdy[0] : ($urandom_range(99) < rdy_pct);
        bus_busy    = (f_busy >= 0) ? f_busy[0] : ($urandom_range(99) < busy_pct);
        redirect    = f_redir ? 1'b1 : ($urandom_range(999) < redir_pm);
        redirect_pc = f_redir ? f_rpc : W'($urandom);
        f_redir = 0;
        if (m_busy) begin
            if (mem_wait < 0) mem_wait = (f_lat >= 0) ? f_lat : $urandom_range(lat_hi, lat_lo);
            mem_ready = (mem_wait == 0);
            if (mem_wait == 0) mem_wait = -1;
            else mem_wait--;
        end else begin
            mem_wait  = -1;
            mem_ready = ($urandom_range(99) < spur_pct);
        end
        data = mem_word(address);
        if (inst_valid && inst_ready) begin
            pc_log.push_back(inst_pc);
            inst_log.push_back(inst);
        end

        pop = exp_v && inst_ready;
        push = 0; discard = 0; start = 0;
        if (m_busy) begin
            if (mem_ready) begin
                if (m_drop || redirect) discard = 1;
                else push = 1;
                m_busy = 0; m_drop = 0;
            end else if (redirect) begin
                m_drop = 1;
            end
        end else if (!redirect && !bus_busy && exp_q.size() < QD) begin
            start = 1;
        end
        if (start) begin m_busy = 1; m_addr = m_pc; end
        if (redirect) begin
            m_dropc += int'(discard) + exp_q.size();
            exp_q.delete();
            m_pc = redirect_pc;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                exp_q.push_back({mem_word(m_pc), m_pc});
                m_pc = m_pc + 16'h1;
                m_fetch++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_stats(input string tag);
`ifdef FETCH_STATS_EN
        chk({tag, "_fetch_count"}, fetch_count, W'(m_fetch));
        chk({tag, "_drop_count"}, drop_count, W'(m_dropc));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        do_reset(1'b0);

        // Sequential fetch, latency 2, decode always ready.
        set_directed(); f_lat = 2; clear_logs();
        run(16);
        chk("s1_addr0", at(addr_log, 0), 16'h0000);
        chk("s1_addr1", at(addr_log, 1), 16'h0001);
        chk("s1_addr2", at(addr_log, 2), 16'h0002);
        chk("s1_pc0", at(pc_log, 0), 16'h0000);
        chk("s1_pc1", at(pc_log, 1), 16'h0001);
        chk("s1_pc2", at(pc_log, 2), 16'h0002);
        chk("s1_inst0", at(inst_log, 0), 16'hA5A5);
        chk("s1_inst1", at(inst_log, 1), 16'hA5A4);
        chk("s1_inst2", at(inst_log, 2), 16'hA5A7);
        check_stats("s1");

        // Decode stalled: queue fills, fetch stops, then resumes at 2.
        do_reset(1'b0); set_directed(); f_rdy = 0; clear_logs();
        run(20);
        chk("s2_nfetch", W'(addr_log.size()), 16'd2);
        chk("s2_head_pc", inst_pc, 16'h0000);
        chk("s2_readM_idle", readM, 0);
        clear_logs(); f_rdy = 1;
        run(10);
        chk("s2_resume_addr", at(addr_log, 0), 16'h0002);
        chk("s2_first_pop", at(pc_log, 0), 16'h0000);

        // Redirect during an in-flight read with slow memory.
        do_reset(1'b0); set_directed(); f_lat = 3;
        for (int i = 0; i < 10 && !m_busy; i++) cycle();
        f_redir = 1; f_rpc = 16'h0040;
        cycle();
        clear_logs();
        run(12);
        chk("s3_new_addr", at(addr_log, 0), 16'h0040);
        chk("s3_first_pc", at(pc_log, 0), 16'h0040);
        chk("s3_first_inst", at(inst_log, 0), 16'hA5E5);
        check_stats("s3");

        // Redirect coincident with mem_ready and a pop.
        do_reset(1'b0); set_directed(); f_rdy = 0; f_lat = 2;
        for (int i = 0; i < 30 && !(exp_q.size() == 1 && m_busy && mem_wait == 0); i++) cycle();
        f_rdy = 1; f_redir = 1; f_rpc = 16'h1234;
        cycle();
        clear_logs();
        cycle();
        chk("s4_empty_after", inst_valid, 0);
        run(8);
        chk("s4_next_addr", at(addr_log, 0), 16'h1234);
        check_stats("s4");

        // bus_busy blocks launch; rising mid-request does not.
        do_reset(1'b0); set_directed(); f_busy = 1; f_rdy = 0; clear_logs();
        run(5);
        chk("s5_no_fetch", W'(addr_log.size()), 16'd0);
        f_busy = 0; f_lat = 2;
        for (int i = 0; i < 5 && !m_busy; i++) cycle();
        f_busy = 1;
        run(4);
        chk("s5_pushed_valid", inst_valid, 1);
        chk("s5_pushed_pc", inst_pc, 16'h0000);

        // PC wrap at 0xFFFF.
        do_reset(1'b0); set_directed(); clear_logs();
        f_redir = 1; f_rpc = 16'hFFFF;
        run(14);
        chk("s6_addr_ffff", at(addr_log, 0), 16'hFFFF);
        chk("s6_addr_wrap", at(addr_log, 1), 16'h0000);
        chk("s6_pc_ffff", at(pc_log, 0), 16'hFFFF);
        chk("s6_inst_ffff", at(inst_log, 0), 16'h5A5A);
        chk("s6_pc_wrap", at(pc_log, 1), 16'h0000);

        // Random phase.
        do_reset(1'b0);
        f_rdy = -1; f_busy = -1; f_lat = -1;
        lat_lo = 0; lat_hi = 3; rdy_pct = 60; busy_pct = 15; redir_pm = 30; spur_pct = 5;
        run(3000);
        check_stats("rand");

        // Asynchronous reset in the middle of a request, late mem_ready.
        set_directed(); f_lat = 3;
        for (int i = 0; i < 10 && !m_busy; i++) cycle();
        cycle();
        #2 reset = 1'b1;
        #1 chk("areset_readM", readM, 0);
        chk("areset_state", fsm_state, IDLE);
        do_reset(1'b1);
        f_rdy = -1; f_busy = -1; f_lat = -1; redir_pm = 30; spur_pct = 5;
        run(200);
        check_stats("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
